spio_spinnaker_link_pkt_arbiter: RTL and testbench

- Shares one SpiNNaker link sender packet input (72-bit vld/rdy) between NUM_PORTS packet sources.
- Uses round-robin arbitration with a bounded burst allowance per port.
- Sits upstream of the packet FIFO feeding spio_spinnaker_link_sender, in the sender clock domain.
- Registers its output and keeps a running count of forwarded packets for bench and diagnostic use.

---
 rtl/spio_spinnaker_link_pkt_arbiter.sv | 110 +++++++++++
 tb/tb_spio_spinnaker_link_pkt_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/spio_spinnaker_link_pkt_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spio_spinnaker_link_pkt_arbiter: round-robin, burst-limited N:1 packet
// arbiter feeding one registered 72-bit SpiNNaker link sender input.
// Revision: 1.0
// ----------------------------------------------------------------------------
module spio_spinnaker_link_pkt_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int BURST_LEN = 2
) (
  input  logic                    tb_clk,
  input  logic                    tb_rst,
  input  logic [NUM_PORTS-1:0]    CFG_EN_IN,
  input  logic [NUM_PORTS*72-1:0] PKT_DATA_IN,
  input  logic [NUM_PORTS-1:0]    PKT_VLD_IN,
  output logic [NUM_PORTS-1:0]    PKT_RDY_OUT,
  output logic [71:0]             PKT_DATA_OUT,
  output logic                    PKT_VLD_OUT,
  input  logic                    PKT_RDY_IN,
  output logic [2:0]              GRANT_OUT,
  output logic [31:0]             PKT_CNT_OUT
);
  localparam logic [3:0] c_burst_max = 4'(BURST_LEN - 1);

  logic [NUM_PORTS-1:0] w_req;
  logic                 w_load;
  logic                 w_accept;
  logic                 w_ptr_req;
  logic [2:0]           w_sel;
  logic [71:0]          w_data;

  logic [2:0]           r_ptr;
  logic [3:0]           r_burst;
  logic                 r_started;
  logic [71:0]          r_data;
  logic                 r_vld;
  logic [2:0]           r_grant;
  logic [31:0]          r_pkt_cnt;

  assign w_req    = PKT_VLD_IN & CFG_EN_IN;
  assign w_load   = ~r_vld | PKT_RDY_IN;
  assign w_accept = w_load & (|w_req);

  always_comb begin
    w_ptr_req = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (3'(j) == r_ptr) w_ptr_req = w_req[j];
    end
  end

  // Burst continuation only once a real grant exists, so port 0 wins first
  // out of reset even though the pointer starts on the last port.
  always_comb begin
    logic w_found;
    w_sel   = r_ptr;
    w_found = r_started && w_ptr_req && (r_burst < c_burst_max);
    for (int k = 1; k <= NUM_PORTS; k++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!w_found && w_req[j] && (j == (int'(r_ptr) + k) % NUM_PORTS)) begin
          w_sel   = 3'(j);
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_data      = '0;
    PKT_RDY_OUT = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (3'(j) == w_sel) begin
        w_data         = PKT_DATA_IN[j*72 +: 72];
        PKT_RDY_OUT[j] = w_accept;
      end
    end
  end

  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      r_data    <= '0;
      r_vld     <= 1'b0;
      r_grant   <= '0;
      r_pkt_cnt <= '0;
      r_ptr     <= 3'(NUM_PORTS - 1);
      r_burst   <= '0;
      r_started <= 1'b0;
    end else if (w_accept) begin
      r_data    <= w_data;
      r_vld     <= 1'b1;
      r_grant   <= w_sel;
      r_ptr     <= w_sel;
      r_pkt_cnt <= r_pkt_cnt + 32'd1;
      r_started <= 1'b1;
      // Saturating keeps a long solo run from wrapping into a fresh burst.
      if (w_sel == r_ptr)
        r_burst <= (r_burst < c_burst_max) ? r_burst + 4'd1 : r_burst;
      else
        r_burst <= '0;
    end else if (w_load) begin
      r_vld <= 1'b0;
    end
  end

  assign PKT_DATA_OUT = r_data;
  assign PKT_VLD_OUT  = r_vld;
  assign GRANT_OUT    = r_grant;
  assign PKT_CNT_OUT  = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spio_spinnaker_link_pkt_arbiter.sv
`default_nettype none
// Directed bench for spio_spinnaker_link_pkt_arbiter (NUM_PORTS=4, BURST_LEN=2).
module tb_spio_spinnaker_link_pkt_arbiter;
  logic          tb_clk = 1'b0;
  logic          tb_rst;
  logic [3:0]    cfg_en;
  logic [287:0]  pkt_data;
  logic [3:0]    pkt_vld;
  logic [3:0]    pkt_rdy_out;
  logic [71:0]   data_out;
  logic          vld_out;
  logic          rdy_in;
  logic [2:0]    grant;
  logic [31:0]   cnt;

  int checks = 0;
  int errors = 0;

  spio_spinnaker_link_pkt_arbiter #(.NUM_PORTS(4), .BURST_LEN(2)) dut (
    .tb_clk       (tb_clk),
    .tb_rst       (tb_rst),
    .CFG_EN_IN    (cfg_en),
    .PKT_DATA_IN  (pkt_data),
    .PKT_VLD_IN   (pkt_vld),
    .PKT_RDY_OUT  (pkt_rdy_out),
    .PKT_DATA_OUT (data_out),
    .PKT_VLD_OUT  (vld_out),
    .PKT_RDY_IN   (rdy_in),
    .GRANT_OUT    (grant),
    .PKT_CNT_OUT  (cnt)
  );

  always #5 tb_clk = ~tb_clk;

  function automatic logic [71:0] mk(input int port, input int key);
    return {16'hBEEF, 8'(port), 8'(key), 32'(key), 8'(port) + 8'h02};
  endfunction

  task automatic set_pkt(input int port, input int key);
    pkt_data[port*72 +: 72] = mk(port, key);
  endtask

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int seq1 [8];
    int seq3 [4];
    int seq4 [6];
    seq1 = '{0, 0, 1, 1, 2, 2, 3, 3};
    seq3 = '{1, 1, 3, 3};
    seq4 = '{1, 1, 3, 3, 1, 1};

    tb_rst = 1'b1; cfg_en = 4'hF; pkt_vld = 4'h0; rdy_in = 1'b1; pkt_data = '0;
    for (int i = 0; i < 4; i++) set_pkt(i, 16 + i);
    #2;
    check("rst_vld", 72'(vld_out), 72'(0));
    check("rst_data", data_out, 72'(0));
    check("rst_grant", 72'(grant), 72'(0));
    check("rst_cnt", 72'(cnt), 72'(0));
    @(posedge tb_clk); #1;
    tb_rst = 1'b0; pkt_vld = 4'hF;

    // All four ports, bursts of two
    for (int n = 0; n < 8; n++) begin
      @(posedge tb_clk); #1;
      check("rr_grant", 72'(grant), 72'(seq1[n]));
      check("rr_data", data_out, mk(seq1[n], 16 + seq1[n]));
      check("rr_vld", 72'(vld_out), 72'(1));
    end
    check("rr_cnt", 72'(cnt), 72'(8));

    // Single requester, one packet per cycle
    pkt_vld = 4'b0100; set_pkt(2, 1);
    for (int n = 1; n <= 3; n++) begin
      @(posedge tb_clk); #1;
      check("solo_grant", 72'(grant), 72'(2));
      check("solo_key", 72'(data_out[39:8]), 72'(n));
      set_pkt(2, n + 1);
    end
    check("solo_cnt", 72'(cnt), 72'(11));

    // Stall with port 0 held in the output register
    pkt_vld = 4'b0001; set_pkt(0, 'h55);
    @(posedge tb_clk); #1;
    check("hold_grant", 72'(grant), 72'(0));
    rdy_in = 1'b0; pkt_vld = 4'b1010;
    for (int i = 1; i < 4; i++) set_pkt(i, 'h20 + i);
    #1;
    check("stall_rdy", 72'(pkt_rdy_out), 72'(0));
    for (int n = 0; n < 10; n++) begin
      @(posedge tb_clk); #1;
      check("stall_data", data_out, mk(0, 'h55));
      check("stall_vld", 72'(vld_out), 72'(1));
      check("stall_rdy", 72'(pkt_rdy_out), 72'(0));
    end
    rdy_in = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge tb_clk); #1;
      check("rel_grant", 72'(grant), 72'(seq3[n]));
      check("rel_data", data_out, mk(seq3[n], 'h20 + seq3[n]));
    end
    check("rel_cnt", 72'(cnt), 72'(16));

    // Ports 0 and 2 masked off
    cfg_en = 4'b1010; pkt_vld = 4'hF;
    for (int i = 0; i < 4; i++) set_pkt(i, 'h30 + i);
    #1;
    check("mask_rdy", 72'(pkt_rdy_out), 72'(4'b0010));
    for (int n = 0; n < 6; n++) begin
      @(posedge tb_clk); #1;
      check("mask_grant", 72'(grant), 72'(seq4[n]));
      check("mask_data", data_out, mk(seq4[n], 'h30 + seq4[n]));
      if (n < 5) check("mask_rdy", 72'(pkt_rdy_out), 72'(4'b0001 << seq4[n+1]));
    end
    check("mask_cnt", 72'(cnt), 72'(22));
    pkt_vld = 4'h0;
    @(posedge tb_clk); #1;
    check("drain_vld", 72'(vld_out), 72'(0));
    check("drain_grant", 72'(grant), 72'(1));

    // Counter wrap
    force dut.r_pkt_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_pkt_cnt;
    check("wrap_pre", 72'(cnt), 72'(32'hFFFF_FFFF));
    cfg_en = 4'hF; pkt_vld = 4'b0001;
    @(posedge tb_clk); #1;
    check("wrap_zero", 72'(cnt), 72'(0));
    check("wrap_grant", 72'(grant), 72'(0));
    @(posedge tb_clk); #1;
    check("wrap_one", 72'(cnt), 72'(1));

    // Asynchronous reset mid-packet
    pkt_vld = 4'b0100;
    @(posedge tb_clk); #1;
    check("pre_rst_grant", 72'(grant), 72'(2));
    check("pre_rst_vld", 72'(vld_out), 72'(1));
    #2 tb_rst = 1'b1;
    #1;
    check("arst_vld", 72'(vld_out), 72'(0));
    check("arst_cnt", 72'(cnt), 72'(0));
    check("arst_data", data_out, 72'(0));
    check("arst_grant", 72'(grant), 72'(0));
    pkt_vld = 4'hF;
    #2 tb_rst = 1'b0;
    @(posedge tb_clk); #1;
    check("post_rst_grant", 72'(grant), 72'(0));
    check("post_rst_cnt", 72'(cnt), 72'(1));
    check("post_rst_data", data_out, mk(0, 'h30));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
